// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register driving a combinational imem, feeding a small in-order queue to decode.
// Head appears one edge after fetch; fetch stalls while the queue is full and not draining.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] fetch_cnt
);

    localparam int            PW      = $clog2(QDEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(QDEPTH);
    localparam logic [31:0]   START_C = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } entry_t;

    entry_t        q_mem_q [QDEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   fetch_cnt_q, fetch_cnt_d;
    logic          push;
    logic          pop;

    // Redirect suppresses both sides of the queue so stale words are never handed to decode.
    always_comb begin
        pop  = (count_q != '0) & instr_ready & ~redirect_valid;
        push = ~redirect_valid & ((count_q < DEPTH_C) | pop);
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        fetch_pc_d  = fetch_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (redirect_valid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else begin
            if (push) begin
                tail_d      = tail_q + (PW)'(1);
                fetch_pc_d  = fetch_pc_q + 32'd4;
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
            if (pop) begin
                head_d = head_q + (PW)'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            fetch_pc_q  <= START_C;
            fetch_cnt_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_mem_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            if (push) begin
                q_mem_q[tail_q] <= '{pc: fetch_pc_q, dat: idata};
            end
        end
    end

    always_comb begin
        iaddr       = fetch_pc_q;
        instr_valid = (count_q != '0);
        instr       = q_mem_q[head_q].dat;
        instr_pc    = q_mem_q[head_q].pc;
        fetch_cnt   = fetch_cnt_q;
    end

endmodule
